// File: rtl/freq_edge_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a GATE_CYCLES window.
// Optional FREQ_METER_PERIOD_EN adds period_cycles, the last edge-to-edge spacing seen in the window.
module freq_edge_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] edge_count,
    output logic             overflow
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [CNT_W-1:0] period_cycles
`endif
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]    GATE_ZERO = {GW{1'b0}};
    localparam logic [GW-1:0]    GATE_ONE  = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   edge_s;
    logic                   count_s;
    logic                   gate_open_s;
    logic                   window_end_s;
    logic [GW-1:0]          gate_cnt_r;
    logic [CNT_W-1:0]       work_r;
    logic [CNT_W-1:0]       work_next_s;
    logic                   sat_r;
    logic                   sat_next_s;
    logic                   busy_r;
    logic                   valid_r;
    logic [CNT_W-1:0]       edge_count_r;
    logic                   overflow_r;

    // Synchronizer chain plus delay flop for rising-edge detection; runs in every state.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign edge_s = sync_r[SYNC_STAGES-1] & ~prev_r;

    // State register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and window control strobes.
    always_comb begin
        state_next_s = state_r;
        gate_open_s  = 1'b0;
        window_end_s = 1'b0;
        count_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = GATE;
                    gate_open_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GATE: begin
                count_s = edge_s;
                if (gate_cnt_r == GATE_ZERO) begin
                    state_next_s = DONE;
                    window_end_s = 1'b1;
                end else begin
                    state_next_s = GATE;
                end
            end
            DONE: begin
                if (cont) begin
                    state_next_s = GATE;
                    gate_open_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Saturating edge counter; the final gate cycle's edge is folded in before reporting.
    always_comb begin
        work_next_s = work_r;
        sat_next_s  = sat_r;
        if (count_s) begin
            if (work_r == CNT_MAX) begin
                sat_next_s = 1'b1;
            end else begin
                work_next_s = work_r + CNT_ONE;
            end
        end else begin
            work_next_s = work_r;
        end
    end

    // Gate timer, working counter and registered result outputs.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            gate_cnt_r   <= GATE_ZERO;
            work_r       <= CNT_ZERO;
            sat_r        <= 1'b0;
            busy_r       <= 1'b0;
            valid_r      <= 1'b0;
            edge_count_r <= CNT_ZERO;
            overflow_r   <= 1'b0;
        end else begin
            busy_r  <= (state_next_s == GATE);
            valid_r <= window_end_s;
            if (gate_open_s) begin
                gate_cnt_r <= GATE_LOAD;
                work_r     <= CNT_ZERO;
                sat_r      <= 1'b0;
            end else if (state_r == GATE) begin
                work_r <= work_next_s;
                sat_r  <= sat_next_s;
                if (gate_cnt_r != GATE_ZERO) begin
                    gate_cnt_r <= gate_cnt_r - GATE_ONE;
                end
            end
            if (window_end_s) begin
                edge_count_r <= work_next_s;
                overflow_r   <= sat_next_s;
            end
        end
    end

    assign busy       = busy_r;
    assign valid      = valid_r;
    assign edge_count = edge_count_r;
    assign overflow   = overflow_r;

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] interval_r;
    logic [CNT_W-1:0] last_per_r;
    logic [CNT_W-1:0] last_per_next_s;
    logic [CNT_W-1:0] period_r;
    logic             seen_s;

    // A spacing exists only once an earlier edge has been counted in this window.
    always_comb begin
        seen_s          = (work_r != CNT_ZERO) | sat_r;
        last_per_next_s = last_per_r;
        if (count_s && seen_s) begin
            if (interval_r == CNT_MAX) begin
                last_per_next_s = CNT_MAX;
            end else begin
                last_per_next_s = interval_r + CNT_ONE;
            end
        end else begin
            last_per_next_s = last_per_r;
        end
    end

    // Free-running interval counter and last-spacing capture.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            interval_r <= CNT_ZERO;
            last_per_r <= CNT_ZERO;
            period_r   <= CNT_ZERO;
        end else begin
            if (count_s) begin
                interval_r <= CNT_ZERO;
            end else if (interval_r != CNT_MAX) begin
                interval_r <= interval_r + CNT_ONE;
            end
            if (gate_open_s) begin
                last_per_r <= CNT_ZERO;
            end else begin
                last_per_r <= last_per_next_s;
            end
            if (window_end_s) begin
                period_r <= last_per_next_s;
            end
        end
    end

    assign period_cycles = period_r;
`endif

endmodule

// File: tb/tb_freq_edge_meter.sv
// Self-checking bench for freq_edge_meter: table-driven windows, corner sequences and random windows
// checked against a sample-history reference model. Two instances (CNT_W=32 and CNT_W=4) share stimulus.
module tb_freq_edge_meter;

    localparam int G  = 1000;
    localparam int S  = 2;
    localparam int HN = 65536;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sig_in = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        busy, valid, overflow;
    logic [31:0] edge_count;
    logic        busy4, valid4, overflow4;
    logic [3:0]  edge_count4;
`ifdef FREQ_METER_PERIOD_EN
    logic [31:0] period_cycles;
    logic [3:0]  period_cycles4;
`endif

    freq_edge_meter #(.GATE_CYCLES(G), .CNT_W(32), .SYNC_STAGES(S)) dut (
        .sys_clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
        .busy(busy), .valid(valid), .edge_count(edge_count), .overflow(overflow)
`ifdef FREQ_METER_PERIOD_EN
        , .period_cycles(period_cycles)
`endif
    );

    freq_edge_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(S)) dut4 (
        .sys_clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
        .busy(busy4), .valid(valid4), .edge_count(edge_count4), .overflow(overflow4)
`ifdef FREQ_METER_PERIOD_EN
        , .period_cycles(period_cycles4)
`endif
    );

    typedef struct {
        int mode;
        int per;
        int e32;
        int e4;
        bit eov4;
        int eper;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit hist [HN];
    int mode = 1, per = 10, lvl = 0, rise_n = 0, dens = 50;
    int valid_seen = 0, busy_cnt = 0, last_valid_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // hist[n] is the sig_in value sampled by the DUT at posedge n.
    task automatic drive_sig();
        int n = cyc + 1;
        bit v;
        case (mode)
            0: v = ((n % per) < (per / 2));
            1: v = lvl[0];
            2: v = ($urandom_range(0, 99) < dens);
            3: v = (n >= rise_n);
            default: v = 1'b0;
        endcase
        sig_in = v;
        if (n < HN) hist[n] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (valid) begin
            valid_seen++;
            last_valid_cyc = cyc;
        end
        if (busy) busy_cnt++;
        drive_sig();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start(output int p);
        start = 1'b1;
        p = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        int v0 = valid_seen;
        while (valid_seen == v0 && k < G + 50) begin
            tick();
            k++;
        end
        chk({name, "_valid_seen"}, 64'(valid_seen != v0), 64'd1);
    endtask

    // Reference: an edge counted at posedge e is a 0->1 step in the sampled history SYNC_STAGES
    // samples earlier; the window opened at posedge p counts edges at posedges p+1 .. p+G.
    function automatic void ref_window(input int p, output longint cnt, output longint sp);
        int prev_e = -1;
        cnt = 0;
        sp  = 0;
        for (int e = p + 1; e <= p + G; e++) begin
            int n = e - S;
            if (n >= 1 && n < HN && hist[n] && !hist[n-1]) begin
                cnt++;
                if (prev_e >= 0) sp = e - prev_e;
                prev_e = e;
            end
        end
    endfunction

    task automatic check_window(input string name, input int p, input bit use_exp,
                                input int e32, input int e4, input bit eov4, input int eper);
        longint mc, mp;
        ref_window(p, mc, mp);
        chk({name, "_cnt_model"}, edge_count, mc);
        chk({name, "_ov"}, overflow, 0);
        chk({name, "_cnt4_model"}, edge_count4, (mc > 15) ? 15 : mc);
        chk({name, "_ov4_model"}, overflow4, (mc > 15) ? 1 : 0);
        chk({name, "_valid_lat"}, last_valid_cyc - p, G);
        chk({name, "_busy_done"}, busy, 0);
        if (use_exp) begin
            chk({name, "_cnt_exp"}, edge_count, e32);
            chk({name, "_cnt4_exp"}, edge_count4, e4);
            chk({name, "_ov4_exp"}, overflow4, eov4);
        end
`ifdef FREQ_METER_PERIOD_EN
        chk({name, "_per_model"}, period_cycles, mp);
        if (use_exp) chk({name, "_per_exp"}, period_cycles, eper);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        int   p, v0, v1, v2, v3;
        tbl[0] = '{0, 10,   100, 15, 1'b1, 10};
        tbl[1] = '{0, 4,    250, 15, 1'b1, 4};
        tbl[2] = '{1, 2,    0,   0,  1'b0, 0};
        tbl[3] = '{0, 8,    125, 15, 1'b1, 8};
        tbl[4] = '{0, 2,    500, 15, 1'b1, 2};
        tbl[5] = '{0, 100,  10,  10, 1'b0, 100};
        tbl[6] = '{0, 250,  4,   4,  1'b0, 250};
        tbl[7] = '{0, 1000, 1,   1,  1'b0, 0};

        ticks(5);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_cnt", edge_count, 0);
        chk("rst_ov", overflow, 0);
        chk("rst_cnt4", edge_count4, 0);
`ifdef FREQ_METER_PERIOD_EN
        chk("rst_per", period_cycles, 0);
`endif
        rst = 1'b0;
        ticks(5);

        // Table-driven single windows.
        for (int i = 0; i < 8; i++) begin
            mode = tbl[i].mode;
            per  = tbl[i].per;
            lvl  = 0;
            ticks(20);
            busy_cnt = 0;
            v0 = valid_seen;
            do_start(p);
            wait_valid($sformatf("tbl%0d", i));
            check_window($sformatf("tbl%0d", i), p, 1'b1, tbl[i].e32, tbl[i].e4, tbl[i].eov4, tbl[i].eper);
            ticks(30);
            chk($sformatf("tbl%0d_busy_cycles", i), busy_cnt, G);
            chk($sformatf("tbl%0d_valid_once", i), valid_seen - v0, 1);
            chk($sformatf("tbl%0d_hold", i), edge_count, tbl[i].e32);
        end

        // Continuous mode: three back-to-back windows, cont dropped during the third.
        mode = 0; per = 10;
        ticks(20);
        cont = 1'b1;
        do_start(p);
        wait_valid("cont1");
        v1 = last_valid_cyc;
        check_window("cont1", p, 1'b1, 100, 15, 1'b1, 10);
        wait_valid("cont2");
        v2 = last_valid_cyc;
        check_window("cont2", v1 + 1, 1'b1, 100, 15, 1'b1, 10);
        ticks(300);
        cont = 1'b0;
        wait_valid("cont3");
        v3 = last_valid_cyc;
        check_window("cont3", v2 + 1, 1'b1, 100, 15, 1'b1, 10);
        chk("cont_gap12", v2 - v1, G + 1);
        chk("cont_gap23", v3 - v2, G + 1);
        tick();
        chk("cont_busy_after", busy, 0);
        v0 = valid_seen;
        ticks(G + 20);
        chk("cont_no_more_valid", valid_seen - v0, 0);

        // Reset in the middle of a window aborts without a report.
        ticks(20);
        do_start(p);
        ticks(500);
        chk("rstmid_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_valid", valid, 0);
        chk("rstmid_cnt", edge_count, 0);
        chk("rstmid_ov4", overflow4, 0);
        chk("rstmid_cnt4", edge_count4, 0);
        v0 = valid_seen;
        ticks(G + 20);
        chk("rstmid_no_valid", valid_seen - v0, 0);

        // start during GATE is ignored.
        ticks(20);
        v0 = valid_seen;
        do_start(p);
        ticks(500);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("startign");
        check_window("startign", p, 1'b1, 100, 15, 1'b1, 10);
        ticks(G + 20);
        chk("startign_one_valid", valid_seen - v0, 1);

        // sig_in high before and through the window gives no edges.
        mode = 1; lvl = 1;
        ticks(20);
        do_start(p);
        wait_valid("held_hi");
        check_window("held_hi", p, 1'b1, 0, 0, 1'b0, 0);
        lvl = 0;
        ticks(20);

        // A rise whose detected edge lands on the last window cycle counts.
        do_start(p);
        mode = 3; rise_n = p + G - S;
        wait_valid("late_in");
        check_window("late_in", p, 1'b1, 1, 1, 1'b0, 0);
        mode = 1; lvl = 0;
        ticks(20);

        // A rise sampled on the last window cycle is detected too late.
        do_start(p);
        mode = 3; rise_n = p + G;
        wait_valid("late_out");
        check_window("late_out", p, 1'b1, 0, 0, 1'b0, 0);
        mode = 1; lvl = 0;
        ticks(20);

        // Random sig_in densities over continuous windows.
        mode = 2;
        dens = $urandom_range(10, 90);
        ticks(20);
        cont = 1'b1;
        do_start(p);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                tick();
                cont = 1'b0;
            end
            wait_valid($sformatf("rnd%0d", k));
            check_window($sformatf("rnd%0d", k), p, 1'b0, 0, 0, 1'b0, 0);
            p = last_valid_cyc + 1;
            dens = $urandom_range(5, 95);
        end
        ticks(10);
        chk("rnd_idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
